// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF array: FSM state encoding,
// default parameter values and the index-width helper.
package ro_puf_pkg;

    localparam int DEF_NUM_RO    = 16;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_WINDOW    = 1024;
    localparam int DEF_RESP_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_COUNT = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4
    } puf_state_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one asynchronous oscillator, detects its rising edges and
// counts them into a saturating counter that can be cleared between windows.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_async,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [1:0] sync;
    logic       prev;
    logic [1:0] armed;
    logic       rise;

    assign rise = sync[1] & ~prev;

    // NOTE: every register here is updated with <= so all flops sample the
    // values from before the edge; a blocking = would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync  <= '0;
            prev  <= 1'b0;
            armed <= '0;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], ro_async};
            prev <= sync[1];
            if (clr) begin
                armed <= '0;
                cnt   <= '0;
            end else begin
                // Edges are ignored until the pipeline holds only samples of
                // the oscillator selected at the clear.
                armed <= {armed[0], 1'b1};
                if (en && armed[1] && rise && (cnt != '1))
                    cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ro_puf_array.sv
// Ring-oscillator PUF comparator: measures two selected oscillators per
// challenge bit and emits one response bit per comparison.
// Optional macro PUF_RAW_COUNT_EN adds raw_a/raw_b final-count outputs.
module ro_puf_array
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO    = DEF_NUM_RO,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WINDOW    = DEF_WINDOW,
    parameter int RESP_BITS = DEF_RESP_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         start,
    input  logic [idx_width(NUM_RO)-1:0] chal_a,
    input  logic [idx_width(NUM_RO)-1:0] chal_b,
    input  logic [NUM_RO-1:0]            ro_in,
    output logic [NUM_RO-1:0]            ro_en,
    output logic                         busy,
    output logic                         done,
    output logic [RESP_BITS-1:0]         resp
`ifdef PUF_RAW_COUNT_EN
    ,
    output logic [CNT_W-1:0]             raw_a,
    output logic [CNT_W-1:0]             raw_b
`endif
);

    localparam int IDX_W = idx_width(NUM_RO);
    localparam int K_W   = idx_width(RESP_BITS);
    localparam int WIN_W = $clog2(WINDOW + 1);

    puf_state_t        state;
    logic [IDX_W-1:0]  base_a;
    logic [IDX_W-1:0]  base_b;
    logic [IDX_W-1:0]  sel_a;
    logic [IDX_W-1:0]  sel_b;
    logic [K_W-1:0]    k;
    logic [WIN_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic              ro_a;
    logic              ro_b;
    logic              cnt_clr;
    logic              cnt_en;
    logic              a_wins;
    logic              last_k;
    logic              win_end;

    // Index arithmetic wraps naturally because NUM_RO is a power of two.
    assign sel_a   = base_a + IDX_W'(k);
    assign sel_b   = base_b + IDX_W'(k);
    assign ro_a    = ro_in[sel_a];
    assign ro_b    = ro_in[sel_b];
    assign cnt_clr = (state == ST_CLEAR);
    assign cnt_en  = (state == ST_COUNT);
    assign a_wins  = (cnt_a > cnt_b);
    assign last_k  = (k == K_W'(RESP_BITS - 1));
    assign win_end = (win_cnt == WIN_W'(WINDOW - 1));
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

    // NOTE: ro_en is cleared before the conditional sets so every path
    // assigns it and no latch is inferred.
    always_comb begin
        ro_en = '0;
        if (state == ST_CLEAR || state == ST_COUNT || state == ST_CMP) begin
            ro_en[sel_a] = 1'b1;
            ro_en[sel_b] = 1'b1;
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .ro_async (ro_a),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .cnt      (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .ro_async (ro_b),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .cnt      (cnt_b)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= ST_IDLE;
            base_a  <= '0;
            base_b  <= '0;
            k       <= '0;
            win_cnt <= '0;
            resp    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start && ena) begin
                        base_a <= chal_a;
                        base_b <= chal_b;
                        k      <= '0;
                        resp   <= '0;
                        state  <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    win_cnt <= '0;
                    state   <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (win_end)
                        state <= ST_CMP;
                    else
                        win_cnt <= win_cnt + 1'b1;
                end
                ST_CMP: begin
                    for (int i = 0; i < RESP_BITS; i++)
                        if (K_W'(i) == k)
                            resp[i] <= a_wins;
                    if (last_k) begin
                        state <= ST_DONE;
                    end else begin
                        k     <= k + 1'b1;
                        state <= ST_CLEAR;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PUF_RAW_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            raw_a <= '0;
            raw_b <= '0;
        end else if (state == ST_CMP) begin
            raw_a <= cnt_a;
            raw_b <= cnt_b;
        end
    end
`endif

endmodule

// File: tb/tb_ro_puf_array.sv
// Randomised bench for ro_puf_array: one DUT for timing/response/wrap checks,
// a second narrow-counter DUT for saturation; both against an edge-count model.
module tb_ro_puf_array;

    localparam int M_NUM  = 16;
    localparam int M_CNTW = 16;
    localparam int M_WIN  = 16;
    localparam int M_RB   = 2;
    localparam int M_LAT  = 1 + M_RB * (M_WIN + 2);
    localparam int M_MAX  = 65535;
    localparam int S_NUM  = 4;
    localparam int S_CNTW = 4;
    localparam int S_WIN  = 64;
    localparam int S_RB   = 1;
    localparam int S_LAT  = 1 + S_RB * (S_WIN + 2);
    localparam int S_MAX  = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        m_start, s_start;
    logic [3:0]  m_chal_a, m_chal_b;
    logic [1:0]  s_chal_a, s_chal_b;
    logic [15:0] m_ro, m_ro_en;
    logic [3:0]  s_ro, s_ro_en;
    logic        m_busy, m_done, s_busy, s_done;
    logic [1:0]  m_resp;
    logic [0:0]  s_resp;
`ifdef PUF_RAW_COUNT_EN
    logic [15:0] m_raw_a, m_raw_b;
    logic [3:0]  s_raw_a, s_raw_b;
`endif

    // Half-periods in clk cycles; all oscillators start in phase.
    int m_half [16] = '{2, 4, 1, 8, 1, 2, 4, 8, 8, 1, 4, 2, 1, 8, 2, 4};
    int s_half [4]  = '{1, 4, 2, 8};
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    ro_puf_array #(.NUM_RO(M_NUM), .CNT_W(M_CNTW), .WINDOW(M_WIN), .RESP_BITS(M_RB)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(m_start),
        .chal_a(m_chal_a), .chal_b(m_chal_b), .ro_in(m_ro), .ro_en(m_ro_en),
        .busy(m_busy), .done(m_done), .resp(m_resp)
`ifdef PUF_RAW_COUNT_EN
        , .raw_a(m_raw_a), .raw_b(m_raw_b)
`endif
    );

    ro_puf_array #(.NUM_RO(S_NUM), .CNT_W(S_CNTW), .WINDOW(S_WIN), .RESP_BITS(S_RB)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(s_start),
        .chal_a(s_chal_a), .chal_b(s_chal_b), .ro_in(s_ro), .ro_en(s_ro_en),
        .busy(s_busy), .done(s_done), .resp(s_resp)
`ifdef PUF_RAW_COUNT_EN
        , .raw_a(s_raw_a), .raw_b(s_raw_b)
`endif
    );

    initial begin
        m_ro = '0;
        s_ro = '0;
        forever begin
            @(posedge clk);
            #2;
            cyc = cyc + 1;
            for (int i = 0; i < 16; i++) m_ro[i] = ((cyc / m_half[i]) % 2) == 1;
            for (int i = 0; i < 4; i++)  s_ro[i] = ((cyc / s_half[i]) % 2) == 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Edges seen in a window: the first two window cycles only refill the
    // synchroniser, so WINDOW-2 sample slots of a period-2h square wave.
    function automatic int cnt_lo(input int half, input int win, input int maxc);
        int v;
        v = (win - 2) / (2 * half);
        return (v > maxc) ? maxc : v;
    endfunction

    function automatic int cnt_hi(input int half, input int win, input int maxc);
        int v;
        v = (win - 2 + 2 * half - 1) / (2 * half);
        return (v > maxc) ? maxc : v;
    endfunction

    // Expected bit A>B; 'known' is 0 when the count ranges overlap.
    function automatic void model_bit(input int ha, input int hb, input int win, input int maxc,
                                      output bit known, output bit val);
        known = 1'b1;
        val   = 1'b0;
        if (ha == hb) return;
        if (cnt_lo(ha, win, maxc) > cnt_hi(hb, win, maxc))       val = 1'b1;
        else if (cnt_hi(ha, win, maxc) <= cnt_lo(hb, win, maxc)) val = 1'b0;
        else                                                    known = 1'b0;
    endfunction

    function automatic logic [15:0] pair_m(input int a, input int b, input int k);
        logic [15:0] v;
        v = '0;
        v[(a + k) % M_NUM] = 1'b1;
        v[(b + k) % M_NUM] = 1'b1;
        return v;
    endfunction

    task automatic run_main(input int a, input int b, input bit poke);
        logic [1:0] exp_v, known;
        bit kn, v;
        int kk;
        for (int k = 0; k < M_RB; k++) begin
            model_bit(m_half[(a + k) % M_NUM], m_half[(b + k) % M_NUM], M_WIN, M_MAX, kn, v);
            known[k] = kn;
            exp_v[k] = v;
        end
        @(negedge clk);
        m_chal_a = 4'(a);
        m_chal_b = 4'(b);
        m_start  = 1'b1;
        @(negedge clk);
        m_start  = 1'b0;
        m_chal_a = 4'($urandom);
        m_chal_b = 4'($urandom);
        for (int o = 1; o <= M_LAT + 1; o++) begin
            if (o > 1) @(negedge clk);
            kk = (o - 1) / (M_WIN + 2);
            if (poke) m_start = (o == 5);
            check("m_ro_en", m_ro_en, (o < M_LAT) ? pair_m(a, b, kk) : 16'h0);
            check("m_busy", m_busy, o <= M_LAT);
            check("m_done", m_done, o == M_LAT);
            if (o == 1) check("m_resp_clr", m_resp, 0);
            if (o >= M_LAT && known != 0) check("m_resp", m_resp & known, exp_v & known);
`ifdef PUF_RAW_COUNT_EN
            if (o == M_LAT) begin
                int ha, hb;
                ha = m_half[(a + M_RB - 1) % M_NUM];
                hb = m_half[(b + M_RB - 1) % M_NUM];
                check("m_raw_a_range", (m_raw_a >= cnt_lo(ha, M_WIN, M_MAX)) && (m_raw_a <= cnt_hi(ha, M_WIN, M_MAX)), 1);
                check("m_raw_b_range", (m_raw_b >= cnt_lo(hb, M_WIN, M_MAX)) && (m_raw_b <= cnt_hi(hb, M_WIN, M_MAX)), 1);
            end
`endif
        end
        m_start = 1'b0;
    endtask

    task automatic run_sat(input int a, input int b);
        bit kn, v;
        int lat;
        model_bit(s_half[a], s_half[b], S_WIN, S_MAX, kn, v);
        @(negedge clk);
        s_chal_a = 2'(a);
        s_chal_b = 2'(b);
        s_start  = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        lat = 0;
        for (int o = 1; o <= S_LAT + 20; o++) begin
            if (o > 1) @(negedge clk);
            if (s_done) begin
                lat = o;
                break;
            end
        end
        check("s_latency", lat, S_LAT);
        if (kn) check("s_resp", s_resp, v);
`ifdef PUF_RAW_COUNT_EN
        check("s_raw_a_range", (s_raw_a >= cnt_lo(s_half[a], S_WIN, S_MAX)) && (s_raw_a <= cnt_hi(s_half[a], S_WIN, S_MAX)), 1);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        rst_n    = 1'b1;
        ena      = 1'b0;
        m_start  = 1'b0;
        s_start  = 1'b0;
        m_chal_a = '0;
        m_chal_b = '0;
        s_chal_a = '0;
        s_chal_b = '0;
        repeat (3) @(negedge clk);
        check("rst_m_busy", m_busy, 0);
        check("rst_m_done", m_done, 0);
        check("rst_m_ro_en", m_ro_en, 0);
        check("rst_m_resp", m_resp, 0);
        check("rst_s_busy", s_busy, 0);
        check("rst_s_ro_en", s_ro_en, 0);
        rst_n = 1'b0;
        ena   = 1'b1;
        @(negedge clk);

        run_main(0, 1, 1'b0);
        run_main(1, 0, 1'b1);
        run_main(3, 3, 1'b0);
        run_main(15, 2, 1'b1);

        // Start with the design disabled must be ignored.
        ena = 1'b0;
        @(negedge clk);
        m_start = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        s_start = 1'b0;
        check("ena0_m_busy", m_busy, 0);
        check("ena0_s_busy", s_busy, 0);
        check("ena0_m_ro_en", m_ro_en, 0);
        ena = 1'b1;

        // Reset during the second comparison window aborts without done.
        @(negedge clk);
        m_chal_a = 4'd0;
        m_chal_b = 4'd1;
        m_start  = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        repeat (24) @(negedge clk);
        check("mid_m_busy", m_busy, 1);
        check("mid_m_resp0", m_resp[0], 1);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check("abort_m_busy", m_busy, 0);
        check("abort_m_resp", m_resp, 0);
        check("abort_m_ro_en", m_ro_en, 0);
        check("abort_m_done", m_done, 0);
        saw_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (m_done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);

        for (int n = 0; n < 16; n++) begin
            run_main($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        run_sat(0, 3);
        run_sat(3, 0);
        run_sat(0, 1);
        run_sat(1, 0);
        run_sat(0, 2);
        run_sat(3, 1);
        run_sat(2, 3);
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            run_sat($urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
